// File: rtl/grid_game_core.sv
// -----------------------------------------------------------------------------
// grid_game_core
//
// Memory-pattern game controller. A pseudo-random target pattern is drawn on
// a GRID_N x GRID_N board, shown for SHOW_CYCLES clocks and then hidden. The
// player rebuilds it by toggling cells, then submits. A match advances the
// level; clearing level LEVELS-1 wins; any mismatch loses and returns to IDLE.
//
// Ports
//   clock        in   rising-edge system clock
//   resetn       in   asynchronous active-low reset
//   go           in   start / submit (rising edge detected internally)
//   input_key    in   cell-select strobe (rising edge detected internally)
//   row, col     in   2-bit coordinates of the selected cell
//   draw_done    in   display has finished drawing the requested frame
//   board        out  CELLS-bit target pattern
//   guess        out  CELLS-bit player pattern
//   level        out  current level, 0-based
//   state        out  FSM state code (IDLE=0 .. DONE=7), for display and debug
//   draw_req     out  frame redraw request
//   audio_en     out  sound enable, high for SOUND_CYCLES clocks per result
//   sound_select out  01 match, 10 mismatch, 11 final match, 00 silent
//   win, lose    out  sticky game outcome flags
//
// Display handshake: draw_req is raised on entry to DRAW_SHOW / DRAW_IN and
// held until draw_done is sampled high on a rising clock edge; draw_req drops
// on that same edge and the FSM moves on. draw_done is ignored in every other
// state, so a display that reports done early or late cannot skip a phase.
// -----------------------------------------------------------------------------
module grid_game_core #(
    parameter int GRID_N       = 3,
    parameter int LEVELS       = 4,
    parameter int SHOW_CYCLES  = 50000000,
    parameter int SOUND_CYCLES = 12500000,
    localparam int CELLS       = GRID_N * GRID_N
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             go,
    input  logic             input_key,
    input  logic [1:0]       row,
    input  logic [1:0]       col,
    input  logic             draw_done,
    output logic [CELLS-1:0] board,
    output logic [CELLS-1:0] guess,
    output logic [2:0]       level,
    output logic [2:0]       state,
    output logic             draw_req,
    output logic             audio_en,
    output logic [1:0]       sound_select,
    output logic             win,
    output logic             lose
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DRAW_SHOW = 3'd1,
        S_SHOW      = 3'd2,
        S_DRAW_IN   = 3'd3,
        S_INPUT     = 3'd4,
        S_EVAL      = 3'd5,
        S_RESULT    = 3'd6,
        S_DONE      = 3'd7
    } state_t;

    localparam logic [31:0] SHOW_LAST  = 32'(SHOW_CYCLES - 1);
    localparam logic [31:0] SOUND_LAST = 32'(SOUND_CYCLES - 1);
    localparam logic [2:0]  LAST_LEVEL = 3'(LEVELS - 1);

    state_t           state_q;
    logic [15:0]      lfsr;
    logic             go_q;
    logic             key_q;
    logic             go_rise;
    logic             key_rise;
    logic [31:0]      cnt;
    logic             match;
    logic [CELLS-1:0] lfsr_slice;
    logic [CELLS-1:0] new_board;
    logic [CELLS-1:0] toggle_mask;
    logic [4:0]       cell_idx;
    logic             in_range;
    logic             eq;
    logic             last_level;

    assign state = state_q;

    // ------------------------------------------------------------------
    // Free-running Fibonacci LFSR, taps 16,14,13,11. It runs in every
    // state so the board drawn depends on how long the player waited.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // ------------------------------------------------------------------
    // Rising-edge detectors. The history flops reset to 1 so an input
    // already held high while reset releases does not count as an edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            go_q  <= 1'b1;
            key_q <= 1'b1;
        end else begin
            go_q  <= go;
            key_q <= input_key;
        end
    end

    assign go_rise  = go & ~go_q;
    assign key_rise = input_key & ~key_q;

    // New board: low CELLS bits of the LFSR, never all-zero so that the
    // player always has at least one cell to find.
    always_comb begin
        lfsr_slice = lfsr[CELLS-1:0];
        new_board  = lfsr_slice;
        if (lfsr_slice == '0) begin
            new_board = {{(CELLS-1){1'b0}}, 1'b1};
        end
    end

    // Cell selection: one-hot mask for row*GRID_N+col, gated by range.
    always_comb begin
        in_range    = ({1'b0, row} < 3'(GRID_N)) && ({1'b0, col} < 3'(GRID_N));
        cell_idx    = 5'(row) * 5'(GRID_N) + 5'(col);
        toggle_mask = '0;
        for (int i = 0; i < CELLS; i++) begin
            toggle_mask[i] = (cell_idx == 5'(i));
        end
    end

    assign eq         = (guess == board);
    assign last_level = (level == LAST_LEVEL);

    // ------------------------------------------------------------------
    // Main FSM. All outputs are registered here, so they change only on
    // a clock edge or on reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            board        <= '0;
            guess        <= '0;
            level        <= '0;
            draw_req     <= 1'b0;
            audio_en     <= 1'b0;
            sound_select <= 2'b00;
            win          <= 1'b0;
            lose         <= 1'b0;
            cnt          <= '0;
            match        <= 1'b0;
        end else begin
            case (state_q)
                // IDLE and DONE share the start action; DONE additionally
                // keeps win visible until the player restarts.
                S_IDLE, S_DONE: begin
                    if (go_rise) begin
                        board    <= new_board;
                        guess    <= '0;
                        level    <= '0;
                        win      <= 1'b0;
                        lose     <= 1'b0;
                        cnt      <= '0;
                        draw_req <= 1'b1;
                        state_q  <= S_DRAW_SHOW;
                    end
                end

                S_DRAW_SHOW: begin
                    if (draw_done) begin
                        draw_req <= 1'b0;
                        cnt      <= '0;
                        state_q  <= S_SHOW;
                    end
                end

                S_SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        cnt      <= '0;
                        draw_req <= 1'b1;
                        state_q  <= S_DRAW_IN;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                S_DRAW_IN: begin
                    if (draw_done) begin
                        draw_req <= 1'b0;
                        state_q  <= S_INPUT;
                    end
                end

                // A key edge always wins over a go edge in the same cycle,
                // so a late toggle is never lost to an early submit.
                S_INPUT: begin
                    if (key_rise) begin
                        if (in_range) begin
                            guess <= guess ^ toggle_mask;
                        end
                    end else if (go_rise) begin
                        state_q <= S_EVAL;
                    end
                end

                // Compare once and pick the sound up front, so RESULT only
                // has to time the tone and act on the stored verdict.
                S_EVAL: begin
                    match        <= eq;
                    audio_en     <= 1'b1;
                    sound_select <= eq ? (last_level ? 2'b11 : 2'b01) : 2'b10;
                    cnt          <= '0;
                    state_q      <= S_RESULT;
                end

                S_RESULT: begin
                    if (cnt == SOUND_LAST) begin
                        cnt          <= '0;
                        audio_en     <= 1'b0;
                        sound_select <= 2'b00;
                        if (!match) begin
                            lose    <= 1'b1;
                            level   <= '0;
                            state_q <= S_IDLE;
                        end else if (last_level) begin
                            win     <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            level    <= level + 3'd1;
                            board    <= new_board;
                            guess    <= '0;
                            draw_req <= 1'b1;
                            state_q  <= S_DRAW_SHOW;
                        end
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
